inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Sequences the IF stage of the pipelined CPU: owns the PC register, drives the combinational instruction-memory read address, and loads the IF/ID pipeline register.
- Applies branch/jump redirects, hazard stalls, and halt/resume control.
- While halted, hands the instruction-memory read port to a debug requester.
- Sits between the hazard/branch logic and the instruction memory.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded at reset.
- NOP_INST, 32'h00000000, instruction injected into IF/ID on flush or bubble.
- BOOT_CYCLES, 2, cycles held in BOOT after reset release (range 1..15).
- DRAIN_CYCLES, 4, bubble cycles issued after a halt request before entering HALT (range 1..15).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- Stall, input, 1, hazard stall: hold PC and IF/ID.
- RedirectValid, input, 1, taken branch/jump resolved this cycle.
- RedirectAddr, input, 32, redirect target; bits [1:0] ignored (forced 00).
- HaltReq, input, 1, request to halt fetch (level, sampled in RUN).
- Resume, input, 1, leave HALT (sampled in HALT only).
- DbgReq, input, 1, debug read request (honoured in HALT only).
- DbgAddr, input, 32, debug read byte address.
- InstAddr, output, 32, read address to instruction memory (combinational mux).
- InstData, input, 32, instruction word returned combinationally by memory.
- IfIdInst, output, 32, registered instruction to ID.
- IfIdPcPlus4, output, 32, registered PC+4 of that instruction.
- IfIdValid, output, 1, IF/ID holds a real instruction.
- Pc, output, 32, current fetch PC.
- Halted, output, 1, high in HALT.
- DbgGrant, output, 1, registered: DbgData is valid this cycle.
- DbgData, output, 32, registered debug read data.

Behaviour:
- Reset (async, rst_n low): state=BOOT; Pc=RESET_PC; IfIdInst=NOP_INST; IfIdPcPlus4=0; IfIdValid=0; Halted=0; DbgGrant=0; DbgData=0; counter=0.
- States:
  - BOOT: PC held; IF/ID holds bubble. Counter counts to BOOT_CYCLES-1, then state becomes RUN.
  - RUN, priority order:
    1. RedirectValid: Pc<={RedirectAddr[31:2],2'b00}; IF/ID<=bubble (IfIdInst=NOP_INST, IfIdValid=0). Redirect overrides Stall.
    2. Stall: Pc and all IF/ID registers hold.
    3. Otherwise: Pc<=Pc+4; IfIdInst<=InstData; IfIdPcPlus4<=Pc+4; IfIdValid<=1.
    - If HaltReq is high with no Stall: the normal/redirect update above still applies, and the next state is DRAIN with counter=0. If Stall is also high, the halt is deferred until Stall drops.
  - DRAIN: no fetch. Pc holds (except redirect). IF/ID<=bubble every cycle. RedirectValid still updates Pc so the halt point is correct. After DRAIN_CYCLES cycles, state becomes HALT.
  - HALT: Halted=1; Pc frozen; IF/ID bubble; Stall and RedirectValid ignored.
    - DbgReq high: InstAddr=DbgAddr. Next cycle: DbgData<=InstData, DbgGrant<=1. Otherwise DbgGrant<=0.
    - Resume: next state RUN; fetch restarts at the frozen Pc; Halted drops the same edge. Resume and DbgReq together: debug read completes (DbgGrant pulses), then RUN.
- InstAddr = DbgAddr when (state==HALT && DbgReq), else Pc. Combinational.
- Arithmetic: Pc+4 is 32-bit modulo; 32'hFFFFFFFC wraps to 32'h00000000.
- DbgGrant is 0 in every state except the cycle after a HALT-state DbgReq.
- rst_n asserted mid-operation (any state, including DRAIN/HALT mid-debug): immediate return to reset values; in-flight debug read dropped.
- Latency:
  - Instruction at Pc appears on IfIdInst one edge after it is presented, absent stall/redirect.
  - Redirect target is fetched in the cycle after RedirectValid.
  - First valid IF/ID instruction arrives BOOT_CYCLES+1 edges after reset release.

Test Plan:
- Reset/boot: memory word0=32'h20080002, word1=32'h20090001; release rst_n. Required: IfIdValid=0 for 2 edges; 3rd edge IfIdInst=32'h20080002, IfIdPcPlus4=4; 4th edge IfIdInst=32'h20090001, Pc=8.
- Stall vs redirect: at Pc=0x14, Stall=1 for 2 cycles, then Stall=1 with RedirectValid=1, RedirectAddr=0x0000000B. Required: Pc and IF/ID hold 2 cycles; then Pc=0x08, IfIdValid=0, IfIdInst=NOP_INST.
- Halt/drain/resume: HaltReq pulse at Pc=0x20. Required: Pc=0x24, 4 bubble cycles, Halted=1. Resume=1: fetch restarts at 0x24; first valid IfIdPcPlus4=0x28.
- Debug read: in HALT, DbgReq=1, DbgAddr=0x28. Required: InstAddr=0x28 the same cycle; next cycle DbgGrant=1 and DbgData=memory word 10. DbgReq asserted in RUN: DbgGrant stays 0 and InstAddr stays Pc.
- Wrap: redirect to 0xFFFFFFFC, no stall. Required: Pc=0xFFFFFFFC, then Pc=0x00000000 with IfIdPcPlus4=0x00000000.
- Async reset mid-DRAIN and mid-HALT with DbgReq=1. Required: all outputs reach reset values without a clock edge; Halted=0 and DbgGrant=0 immediately.

Source files
------------

// File: rtl/inst_fetch_ctrl.sv
// ============================================================================
// inst_fetch_ctrl
// ----------------------------------------------------------------------------
// Instruction-fetch (IF) stage sequencer for the pipelined CPU.
//
// Owns the fetch PC, drives the combinational instruction-memory read address
// and loads the IF/ID pipeline register. It applies branch/jump redirects,
// hazard stalls and halt/resume control. While halted, the instruction-memory
// read port is lent to a debug requester.
//
// Life cycle:  BOOT -> RUN <-> (DRAIN -> HALT) -> RUN ...
//   BOOT  : BOOT_CYCLES settle cycles after reset release, IF/ID holds bubbles.
//   RUN   : normal fetch; redirect beats stall; an unstalled HaltReq starts
//           the drain.
//   DRAIN : DRAIN_CYCLES bubble cycles; a late redirect still moves the PC so
//           the halt point is the architecturally correct one.
//   HALT  : PC frozen; debug reads allowed; Resume restarts fetch at that PC.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   Stall           hazard stall: hold PC and IF/ID
//   RedirectValid   taken branch/jump this cycle
//   RedirectAddr    redirect target (bits [1:0] forced to zero)
//   HaltReq         halt request (level, sampled in RUN)
//   Resume          leave HALT (sampled in HALT only)
//   DbgReq/DbgAddr  debug read request and byte address (HALT only)
//   InstAddr        instruction-memory read address (combinational)
//   InstData        instruction word returned combinationally by memory
//   IfIdInst        registered instruction to ID
//   IfIdPcPlus4     registered PC+4 of that instruction
//   IfIdValid       IF/ID holds a real instruction
//   Pc              current fetch PC
//   Halted          high while in HALT
//   DbgGrant        registered: DbgData valid this cycle
//   DbgData         registered debug read data
// ============================================================================
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INST     = 32'h0000_0000,
    parameter int unsigned BOOT_CYCLES  = 2,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    // Hazard / branch interface
    input  logic        Stall,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectAddr,

    // Halt / debug control
    input  logic        HaltReq,
    input  logic        Resume,
    input  logic        DbgReq,
    input  logic [31:0] DbgAddr,

    // Instruction memory
    output logic [31:0] InstAddr,
    input  logic [31:0] InstData,

    // IF/ID pipeline register
    output logic [31:0] IfIdInst,
    output logic [31:0] IfIdPcPlus4,
    output logic        IfIdValid,

    // Status / debug results
    output logic [31:0] Pc,
    output logic        Halted,
    output logic        DbgGrant,
    output logic [31:0] DbgData
);

    // ------------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // Both BOOT and DRAIN share one 4-bit cycle counter; the terminal value
    // is the cycle count minus one because the counter starts at zero.
    localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e      state_q,      state_d;
    logic [3:0]  cnt_q,        cnt_d;
    logic [31:0] pc_q,         pc_d;
    logic [31:0] ifid_inst_q,  ifid_inst_d;
    logic [31:0] ifid_pcp4_q,  ifid_pcp4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        dbg_grant_q,  dbg_grant_d;
    logic [31:0] dbg_data_q,   dbg_data_d;

    // ------------------------------------------------------------------------
    // Decode of the current cycle's action
    // ------------------------------------------------------------------------
    logic        in_boot, in_run, in_drain, in_halt;
    logic        take_redirect;   // PC loads the redirect target
    logic        fetch_adv;       // PC advances, IF/ID captures InstData
    logic        ifid_bubble;     // IF/ID is loaded with a bubble
    logic        halt_accept;     // RUN -> DRAIN this cycle
    logic        dbg_sel;         // debug owns the memory read port
    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;

    assign in_boot  = (state_q == ST_BOOT);
    assign in_run   = (state_q == ST_RUN);
    assign in_drain = (state_q == ST_DRAIN);
    assign in_halt  = (state_q == ST_HALT);

    // 32-bit addition wraps naturally: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
    assign pc_plus4    = pc_q + 32'd4;
    assign redirect_pc = {RedirectAddr[31:2], 2'b00};

    // Redirect is honoured in RUN (overriding Stall) and in DRAIN, so that a
    // branch resolving in the instructions ahead of the halt still lands.
    assign take_redirect = RedirectValid && (in_run || in_drain);

    assign fetch_adv   = in_run && !RedirectValid && !Stall;

    // A stalled RUN cycle without redirect is the only case that holds IF/ID;
    // every other non-fetch cycle pushes a bubble.
    assign ifid_bubble = in_boot || in_drain || in_halt ||
                         (in_run && RedirectValid);

    // A halt request is deferred while the pipeline is stalled.
    assign halt_accept = in_run && HaltReq && !Stall;

    assign dbg_sel     = in_halt && DbgReq;

    // ------------------------------------------------------------------------
    // FSM next state and shared cycle counter
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here is given a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_BOOT: begin
                if (cnt_q == BOOT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end

            ST_RUN: begin
                if (halt_accept) begin
                    state_d = ST_DRAIN;
                    cnt_d   = 4'd0;
                end
            end

            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_HALT;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end

            ST_HALT: begin
                if (Resume) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_BOOT;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // PC next state
    // ------------------------------------------------------------------------
    always_comb begin
        pc_d = pc_q;
        if (take_redirect) begin
            pc_d = redirect_pc;
        end else if (fetch_adv) begin
            pc_d = pc_plus4;
        end
    end

    // ------------------------------------------------------------------------
    // IF/ID next state
    // ------------------------------------------------------------------------
    // IfIdPcPlus4 is only meaningful alongside IfIdValid, so a bubble leaves
    // it untouched rather than spending a mux leg on it.
    always_comb begin
        ifid_inst_d  = ifid_inst_q;
        ifid_pcp4_d  = ifid_pcp4_q;
        ifid_valid_d = ifid_valid_q;

        if (ifid_bubble) begin
            ifid_inst_d  = NOP_INST;
            ifid_valid_d = 1'b0;
        end else if (fetch_adv) begin
            ifid_inst_d  = InstData;
            ifid_pcp4_d  = pc_plus4;
            ifid_valid_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Debug read port
    // ------------------------------------------------------------------------
    // DbgGrant is a single-cycle pulse following each HALT-state request; the
    // data register keeps the last read so a slow debugger can still see it.
    always_comb begin
        dbg_grant_d = 1'b0;
        dbg_data_d  = dbg_data_q;
        if (dbg_sel) begin
            dbg_grant_d = 1'b1;
            dbg_data_d  = InstData;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // Reset is asynchronous so an in-flight debug read is dropped the moment
    // rst_n falls, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            cnt_q        <= 4'd0;
            pc_q         <= RESET_PC;
            ifid_inst_q  <= NOP_INST;
            ifid_pcp4_q  <= 32'd0;
            ifid_valid_q <= 1'b0;
            dbg_grant_q  <= 1'b0;
            // NOTE: the debug data register is datapath, but it is visible on a
            // port and must read as zero after reset, so it is reset as well.
            dbg_data_q   <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pc_q         <= pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_pcp4_q  <= ifid_pcp4_d;
            ifid_valid_q <= ifid_valid_d;
            dbg_grant_q  <= dbg_grant_d;
            dbg_data_q   <= dbg_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign InstAddr    = dbg_sel ? DbgAddr : pc_q;
    assign Pc          = pc_q;
    assign IfIdInst    = ifid_inst_q;
    assign IfIdPcPlus4 = ifid_pcp4_q;
    assign IfIdValid   = ifid_valid_q;
    assign Halted      = in_halt;
    assign DbgGrant    = dbg_grant_q;
    assign DbgData     = dbg_data_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// ============================================================================
// tb_inst_fetch_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for inst_fetch_ctrl. A small combinational instruction
// memory answers InstAddr. A behavioural model (countdowns and flags, not
// states) predicts every output; a compare process checks the DUT against it
// on each falling clock edge. Directed scenarios add literal expectations.
// ============================================================================
module tb_inst_fetch_ctrl;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          BOOT_N   = 2;
    localparam int          DRAIN_N  = 4;

    // ------------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect_valid, halt_req, resume, dbg_req;
    logic [31:0] redirect_addr, dbg_addr;
    logic [31:0] inst_addr, inst_data;
    logic [31:0] ifid_inst, ifid_pcp4, pc, dbg_data;
    logic        ifid_valid, halted, dbg_grant;

    always #5 clk = ~clk;

    // Combinational instruction memory, 64 words, wraps on address bits [7:2].
    logic [31:0] mem [64];
    assign inst_data = mem[inst_addr[7:2]];

    inst_fetch_ctrl #(
        .RESET_PC     (32'h0000_0000),
        .NOP_INST     (NOP),
        .BOOT_CYCLES  (BOOT_N),
        .DRAIN_CYCLES (DRAIN_N)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Stall         (stall),
        .RedirectValid (redirect_valid),
        .RedirectAddr  (redirect_addr),
        .HaltReq       (halt_req),
        .Resume        (resume),
        .DbgReq        (dbg_req),
        .DbgAddr       (dbg_addr),
        .InstAddr      (inst_addr),
        .InstData      (inst_data),
        .IfIdInst      (ifid_inst),
        .IfIdPcPlus4   (ifid_pcp4),
        .IfIdValid     (ifid_valid),
        .Pc            (pc),
        .Halted        (halted),
        .DbgGrant      (dbg_grant),
        .DbgData       (dbg_data)
    );

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem[a[7:2]];
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    int          m_boot_left;   // settle edges still to go after reset
    int          m_drain_left;  // bubble edges still to go before halting
    bit          m_halted;
    logic [31:0] m_pc, m_inst, m_pcp4, m_dbg_data;
    bit          m_valid, m_grant;

    task automatic model_reset();
        m_boot_left  = BOOT_N;
        m_drain_left = 0;
        m_halted     = 1'b0;
        m_pc         = 32'h0;
        m_inst       = NOP;
        m_pcp4       = 32'h0;
        m_valid      = 1'b0;
        m_grant      = 1'b0;
        m_dbg_data   = 32'h0;
    endtask

    task automatic model_bubble();
        m_inst  = NOP;
        m_valid = 1'b0;
    endtask

    task automatic model_step();
        bit grant_next = 1'b0;
        if (m_boot_left > 0) begin
            m_boot_left--;
            model_bubble();
        end else if (m_halted) begin
            model_bubble();
            if (dbg_req) begin
                m_dbg_data = mem_word(dbg_addr);
                grant_next = 1'b1;
            end
            if (resume) m_halted = 1'b0;
        end else if (m_drain_left > 0) begin
            if (redirect_valid) m_pc = redirect_addr & 32'hFFFF_FFFC;
            model_bubble();
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1'b1;
        end else begin
            if (redirect_valid) begin
                m_pc = redirect_addr & 32'hFFFF_FFFC;
                model_bubble();
            end else if (!stall) begin
                m_inst  = mem_word(m_pc);
                m_pcp4  = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
            if (halt_req && !stall) m_drain_left = DRAIN_N;
        end
        m_grant = grant_next;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ------------------------------------------------------------------------
    // Per-cycle compare against the model (falling edge, away from updates)
    // ------------------------------------------------------------------------
    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [31:0] exp_addr;
            exp_addr = (m_halted && m_boot_left == 0 && dbg_req) ? dbg_addr : m_pc;
            check("m_pc",         pc,                m_pc);
            check("m_ifid_valid", 32'(ifid_valid),   32'(m_valid));
            check("m_ifid_inst",  ifid_inst,         m_inst);
            if (m_valid) check("m_ifid_pcp4", ifid_pcp4, m_pcp4);
            check("m_halted",     32'(halted),       32'(m_halted));
            check("m_dbg_grant",  32'(dbg_grant),    32'(m_grant));
            check("m_dbg_data",   dbg_data,          m_dbg_data);
            check("m_inst_addr",  inst_addr,         exp_addr);
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        halt_req       = 1'b0;
        resume         = 1'b0;
        dbg_req        = 1'b0;
        dbg_addr       = 32'h0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"},        pc,               32'h0);
        check({tag, "_valid"},     32'(ifid_valid),  32'h0);
        check({tag, "_inst"},      ifid_inst,        NOP);
        check({tag, "_pcp4"},      ifid_pcp4,        32'h0);
        check({tag, "_halted"},    32'(halted),      32'h0);
        check({tag, "_grant"},     32'(dbg_grant),   32'h0);
        check({tag, "_dbgdata"},   dbg_data,         32'h0);
        check({tag, "_instaddr"},  inst_addr,        32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | (32'(i) << 8) | 32'(i);
        mem[0] = 32'h2008_0002;
        mem[1] = 32'h2009_0001;

        clear_inputs();
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        #1 rst_n = 1'b0;
        step(); step();
        check_reset_values("rst");

        // ---- Reset / boot ----
        rst_n = 1'b1;
        step(); check("boot_e1_valid", 32'(ifid_valid), 32'h0);
        step(); check("boot_e2_valid", 32'(ifid_valid), 32'h0);
        step();
        check("boot_e3_inst",  ifid_inst,        32'h2008_0002);
        check("boot_e3_pcp4",  ifid_pcp4,        32'h4);
        check("boot_e3_valid", 32'(ifid_valid),  32'h1);
        step();
        check("boot_e4_inst",  ifid_inst,        32'h2009_0001);
        check("boot_e4_pc",    pc,               32'h8);

        // ---- Stall vs redirect at Pc=0x14 ----
        step(); step(); step();
        check("pre_stall_pc", pc, 32'h14);
        stall = 1'b1;
        step();
        check("stall1_pc",   pc,        32'h14);
        check("stall1_inst", ifid_inst, mem[4]);
        step();
        check("stall2_pc",   pc,        32'h14);
        check("stall2_pcp4", ifid_pcp4, 32'h14);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_000B;
        step();
        check("redir_pc",    pc,               32'h08);
        check("redir_valid", 32'(ifid_valid),  32'h0);
        check("redir_inst",  ifid_inst,        NOP);
        clear_inputs();

        // ---- Halt / drain / resume at Pc=0x20 ----
        for (int i = 0; i < 6; i++) step();
        check("pre_halt_pc", pc, 32'h20);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("halt_pc",    pc,              32'h24);
        check("halt_inst",  ifid_inst,       mem[8]);
        for (int i = 0; i < DRAIN_N - 1; i++) begin
            step();
            check("drain_halted", 32'(halted),     32'h0);
            check("drain_valid",  32'(ifid_valid), 32'h0);
        end
        step();
        check("halted_set", 32'(halted), 32'h1);
        check("halted_pc",  pc,          32'h24);
        // Stall and redirect are ignored while halted.
        stall = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'h100;
        step();
        check("halt_ignore_pc", pc, 32'h24);
        clear_inputs();

        // ---- Debug read in HALT ----
        dbg_req = 1'b1; dbg_addr = 32'h28;
        #1 check("dbg_instaddr", inst_addr, 32'h28);
        step();
        dbg_req = 1'b0;
        check("dbg_grant", 32'(dbg_grant), 32'h1);
        check("dbg_data",  dbg_data,       mem[10]);
        step();
        check("dbg_grant_drop", 32'(dbg_grant), 32'h0);
        // Resume together with a debug read: read completes, then RUN.
        resume = 1'b1; dbg_req = 1'b1; dbg_addr = 32'h30;
        step();
        resume = 1'b0;
        check("resume_halted", 32'(halted),    32'h0);
        check("resume_grant",  32'(dbg_grant), 32'h1);
        check("resume_data",   dbg_data,       mem[12]);
        check("run_dbg_addr",  inst_addr,      32'h24);
        step();
        check("run_dbg_grant", 32'(dbg_grant), 32'h0);
        check("resume_pcp4",   ifid_pcp4,      32'h28);
        check("resume_inst",   ifid_inst,      mem[9]);
        clear_inputs();

        // ---- Wrap at the top of the address space ----
        redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFC;
        step();
        clear_inputs();
        check("wrap_pc_top", pc, 32'hFFFF_FFFC);
        step();
        check("wrap_pc",    pc,        32'h0);
        check("wrap_pcp4",  ifid_pcp4, 32'h0);
        check("wrap_inst",  ifid_inst, mem[63]);

        // ---- Halt deferred by stall, redirect during drain ----
        stall = 1'b1; halt_req = 1'b1;
        step();
        check("defer_pc", pc, 32'h0);
        stall = 1'b0;
        step();
        halt_req = 1'b0;
        check("defer_go_pc", pc, 32'h4);
        redirect_valid = 1'b1; redirect_addr = 32'h41;
        step();
        clear_inputs();
        check("drain_redir_pc", pc, 32'h40);
        step(); step();
        check("drain_redir_halted", 32'(halted), 32'h0);
        step();
        check("drain_redir_halt", 32'(halted), 32'h1);

        // ---- Async reset mid-HALT with a debug read in flight ----
        dbg_req = 1'b1; dbg_addr = 32'h28;
        step();
        check("pre_rst_grant", 32'(dbg_grant), 32'h1);
        #3 rst_n = 1'b0;
        #1 check_reset_values("rst_halt");
        clear_inputs();
        step();
        rst_n = 1'b1;

        // ---- Async reset mid-DRAIN ----
        step(); step();
        step(); step(); step();
        check("rerun_pc", pc, 32'hC);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        step();
        check("pre_rst_drain_pc", pc, 32'h10);
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_drain");
        step();
        rst_n = 1'b1;
        step(); step(); step();
        check("reboot_inst", ifid_inst, 32'h2008_0002);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
